// File: rtl/score_engine.sv
// score_engine: multi-lane rhythm-game scorer. Resolves per-lane judgements,
// tracks combo / best combo / misses, and accumulates a saturating score
// through a two-stage pipeline (stage 1 registers base points and the
// multiplier, stage 2 multiplies and adds into the score).
module score_engine #(
    parameter int LANES       = 4,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int TIER_SHIFT  = 4,
    parameter int MAX_MULT    = 17,
    parameter int PTS_PERFECT = 10,
    parameter int PTS_GOOD    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         game_state,
    input  logic               judge_valid,
    input  logic [LANES-1:0]   judge_perfect,
    input  logic [LANES-1:0]   judge_good,
    input  logic [LANES-1:0]   judge_miss,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [COMBO_W-1:0] miss_count,
    output logic [4:0]         multiplier,
    output logic               full_combo
);
    localparam logic [1:0] ST_SONG_SELECT = 2'd1;
    localparam logic [1:0] ST_GAME_PLAY   = 2'd2;
    localparam logic [1:0] ST_GAME_OVER   = 2'd3;

    localparam int CNT_W    = $clog2(LANES + 1);
    localparam int PTS_MAX  = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
    localparam int BASE_W   = $clog2(PTS_MAX * LANES + 1);
    localparam int ADD_W    = BASE_W + 5;
    localparam int SUM_W    = ((SCORE_W > ADD_W) ? SCORE_W : ADD_W) + 1;
    localparam int CSUM_W   = COMBO_W + CNT_W + 1;

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [COMBO_W-1:0] r_combo, r_max_combo, r_miss;
    logic [SCORE_W-1:0] r_score;
    logic               r_score_valid;
    logic [BASE_W-1:0]  r_base;
    logic [4:0]         r_mult;
    logic               r_s1_valid;

    logic [CNT_W-1:0]   w_np, w_ng, w_nm;
    logic               w_accept, w_clear;
    logic [31:0]        w_mult_raw;
    logic [4:0]         w_mult;
    logic [CSUM_W-1:0]  w_csum, w_msum;
    logic [COMBO_W-1:0] w_combo_nxt, w_miss_nxt;
    logic [BASE_W-1:0]  w_base;
    logic [ADD_W-1:0]   w_add;
    logic [SUM_W-1:0]   w_ssum;

    assign w_accept = judge_valid && (game_state == ST_GAME_PLAY);
    assign w_clear  = (game_state == ST_SONG_SELECT);

    // Per-lane priority resolution (perfect > good > miss) and counting
    always_comb begin
        w_np = '0;
        w_ng = '0;
        w_nm = '0;
        for (int l = 0; l < LANES; l++) begin
            if (judge_perfect[l])   w_np = w_np + CNT_W'(1);
            else if (judge_good[l]) w_ng = w_ng + CNT_W'(1);
            else if (judge_miss[l]) w_nm = w_nm + CNT_W'(1);
        end
    end

    // Tiered multiplier from the current combo register
    always_comb begin
        w_mult_raw = 32'((r_combo - COMBO_W'(1)) >> TIER_SHIFT) + 32'd2;
        if (r_combo == '0)
            w_mult = 5'd1;
        else if (w_mult_raw > 32'(MAX_MULT))
            w_mult = 5'(MAX_MULT);
        else
            w_mult = w_mult_raw[4:0];
    end

    // Next combo / miss count with clamping, and base points of the event
    always_comb begin
        w_csum = CSUM_W'(r_combo) + CSUM_W'(w_np) + CSUM_W'(w_ng);
        w_msum = CSUM_W'(r_miss) + CSUM_W'(w_nm);
        if (w_nm != '0)
            w_combo_nxt = '0;
        else if (w_csum > CSUM_W'(COMBO_MAX))
            w_combo_nxt = COMBO_MAX;
        else
            w_combo_nxt = w_csum[COMBO_W-1:0];
        w_miss_nxt = (w_msum > CSUM_W'(COMBO_MAX)) ? COMBO_MAX : w_msum[COMBO_W-1:0];
        w_base = BASE_W'(PTS_PERFECT * int'(w_np) + PTS_GOOD * int'(w_ng));
    end

    // Stage 2 arithmetic: full-width product, compare before clamping
    always_comb begin
        w_add  = ADD_W'(r_base) * ADD_W'(r_mult);
        w_ssum = SUM_W'(r_score) + SUM_W'(w_add);
    end

    // Stage 1: capture base/multiplier and update combo counters on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_combo     <= '0;
            r_max_combo <= '0;
            r_miss      <= '0;
            r_base      <= '0;
            r_mult      <= '0;
            r_s1_valid  <= 1'b0;
        end else if (w_clear) begin
            r_combo     <= '0;
            r_max_combo <= '0;
            r_miss      <= '0;
            r_base      <= '0;
            r_mult      <= '0;
            r_s1_valid  <= 1'b0;
        end else if (w_accept) begin
            r_combo     <= w_combo_nxt;
            r_miss      <= w_miss_nxt;
            if (w_combo_nxt > r_max_combo) r_max_combo <= w_combo_nxt;
            r_base      <= w_base;
            r_mult      <= w_mult;
            r_s1_valid  <= 1'b1;
        end else begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Stage 2: saturating score accumulate with a one-cycle valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score       <= '0;
            r_score_valid <= 1'b0;
        end else if (w_clear) begin
            r_score       <= '0;
            r_score_valid <= 1'b0;
        end else begin
            r_score_valid <= r_s1_valid;
            if (r_s1_valid)
                r_score <= (w_ssum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_ssum[SCORE_W-1:0];
        end
    end

    assign score       = r_score;
    assign score_valid = r_score_valid;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign miss_count  = r_miss;
    assign multiplier  = w_mult;
    assign full_combo  = (game_state == ST_GAME_OVER) && (r_miss == '0) && (r_max_combo != '0);
endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: default instance plus a narrow
// (SCORE_W=8, COMBO_W=4) instance sharing the same stimulus for clamping.
module tb_score_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] game_state = 2'd0;
    logic       judge_valid = 1'b0;
    logic [3:0] judge_perfect = '0, judge_good = '0, judge_miss = '0;

    logic [15:0] score;
    logic        score_valid, full_combo;
    logic [7:0]  combo, max_combo, miss_count;
    logic [4:0]  multiplier;

    logic [7:0]  s_score;
    logic        s_score_valid, s_full_combo;
    logic [3:0]  s_combo, s_max_combo, s_miss_count;
    logic [4:0]  s_multiplier;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    score_engine dut (
        .clk(clk), .rst(rst), .game_state(game_state), .judge_valid(judge_valid),
        .judge_perfect(judge_perfect), .judge_good(judge_good), .judge_miss(judge_miss),
        .score(score), .score_valid(score_valid), .combo(combo), .max_combo(max_combo),
        .miss_count(miss_count), .multiplier(multiplier), .full_combo(full_combo)
    );

    score_engine #(.SCORE_W(8), .COMBO_W(4)) dut_s (
        .clk(clk), .rst(rst), .game_state(game_state), .judge_valid(judge_valid),
        .judge_perfect(judge_perfect), .judge_good(judge_good), .judge_miss(judge_miss),
        .score(s_score), .score_valid(s_score_valid), .combo(s_combo),
        .max_combo(s_max_combo), .miss_count(s_miss_count),
        .multiplier(s_multiplier), .full_combo(s_full_combo)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [3:0] p, input logic [3:0] g, input logic [3:0] m);
        judge_valid = 1'b1; judge_perfect = p; judge_good = g; judge_miss = m;
        step();
        judge_valid = 1'b0; judge_perfect = '0; judge_good = '0; judge_miss = '0;
    endtask

    task automatic new_song();
        game_state = 2'd1;
        step();
        game_state = 2'd2;
    endtask

    initial begin
        // reset and clear
        #12 rst = 1'b0;
        #1;
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_mult", multiplier, 1);
        chk("rst_sv", score_valid, 0);
        chk("rst_fc", full_combo, 0);
        new_song();

        // first two perfects
        ev(4'b0001, 4'b0000, 4'b0000);
        chk("t1_combo", combo, 1);
        chk("t1_sv_early", score_valid, 0);
        step();
        chk("t1_score", score, 10);
        chk("t1_sv", score_valid, 1);
        chk("t1_mult", multiplier, 2);
        step();
        chk("t1_sv_drop", score_valid, 0);
        ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("t2_score", score, 30);
        chk("t2_combo", combo, 2);

        // tier boundary, back-to-back events
        new_song();
        chk("clr_score", score, 0);
        for (int i = 0; i < 16; i++) ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("tier_combo16", combo, 16);
        chk("tier_mult16", multiplier, 2);
        chk("tier_score16", score, 310);
        ev(4'b0001, 4'b0000, 4'b0000);
        chk("tier_combo17", combo, 17);
        chk("tier_mult17", multiplier, 3);
        step();
        chk("tier_score17", score, 330);
        ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("tier_score18", score, 360);

        // multi-lane priority at combo 5
        new_song();
        for (int i = 0; i < 5; i++) ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("ml_pre", score, 90);
        ev(4'b1001, 4'b0100, 4'b1000);
        chk("ml_combo", combo, 8);
        chk("ml_miss", miss_count, 0);
        step();
        chk("ml_score", score, 140);

        // miss resets combo
        new_song();
        for (int i = 0; i < 20; i++) ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("mr_pre", score, 420);
        ev(4'b0000, 4'b0000, 4'b0010);
        chk("mr_combo", combo, 0);
        chk("mr_max", max_combo, 20);
        chk("mr_miss", miss_count, 1);
        chk("mr_mult", multiplier, 1);
        step();
        chk("mr_score", score, 420);
        chk("mr_sv", score_valid, 1);
        ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("mr_after", score, 430);

        // empty event still pulses
        ev(4'b0000, 4'b0000, 4'b0000);
        chk("empty_combo", combo, 1);
        step();
        chk("empty_sv", score_valid, 1);
        chk("empty_score", score, 430);

        // clamping on the narrow instance
        new_song();
        ev(4'b1111, 4'b0000, 4'b0000); step();
        chk("sat_s1", s_score, 40);  chk("sat_c1", s_combo, 4);
        ev(4'b1111, 4'b0000, 4'b0000); step();
        chk("sat_s2", s_score, 120); chk("sat_c2", s_combo, 8);
        ev(4'b1111, 4'b0000, 4'b0000); step();
        chk("sat_s3", s_score, 200); chk("sat_c3", s_combo, 12);
        ev(4'b1111, 4'b0000, 4'b0000); step();
        chk("sat_s4", s_score, 255); chk("sat_c4", s_combo, 15);
        ev(4'b1111, 4'b0000, 4'b0000); step();
        chk("sat_s5", s_score, 255); chk("sat_c5", s_combo, 15);
        chk("sat_max", s_max_combo, 15);
        chk("sat_mult", s_multiplier, 2);

        // IDLE drops events
        new_song();
        game_state = 2'd0;
        ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("idle_combo", combo, 0);
        chk("idle_sv", score_valid, 0);
        chk("idle_score", score, 0);

        // SONG_SELECT discards in-flight entry
        game_state = 2'd2;
        ev(4'b0001, 4'b0000, 4'b0000);
        chk("ss_combo_pre", combo, 1);
        game_state = 2'd1;
        step();
        chk("ss_sv", score_valid, 0);
        chk("ss_combo", combo, 0);
        chk("ss_max", max_combo, 0);
        step();
        chk("ss_sv2", score_valid, 0);
        chk("ss_score", score, 0);

        // GAME_OVER: in-flight completes, full combo, new events dropped
        game_state = 2'd2;
        ev(4'b0001, 4'b0000, 4'b0000);
        ev(4'b0000, 4'b0010, 4'b0000);
        chk("go_fc_play", full_combo, 0);
        game_state = 2'd3;
        step();
        chk("go_sv", score_valid, 1);
        chk("go_score", score, 20);
        chk("go_fc", full_combo, 1);
        ev(4'b0001, 4'b0000, 4'b0000);
        step();
        chk("go_combo", combo, 2);
        chk("go_sv_drop", score_valid, 0);

        // async reset mid-pipeline
        game_state = 2'd2;
        ev(4'b0001, 4'b0000, 4'b0000);
        #2 rst = 1'b1;
        #1;
        chk("arst_combo", combo, 0);
        chk("arst_score", score, 0);
        chk("arst_sv", score_valid, 0);
        step();
        chk("arst_sv2", score_valid, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
